// File: rtl/char_filter.sv
// Character filter between the receive display FIFO and the text display: pops, classifies, tracks the cursor column.
// Latency: a FIFO head seen at edge N gives in_read in cycle N+1 and out_write at the earliest in cycle N+3; at most one character every 4 cycles.
// Backpressure: stalls in WAIT/TAB while out_ready=0 and never pops with a character or tab count pending. Define CHAR_FILTER_TAB_EN to expand TAB.
module char_filter #(
    parameter int COLS      = 80,
    parameter int COL_BITS  = 7,
    parameter int TAB_WIDTH = 8
) (
    input  logic                clk_in,
    input  logic                rstn_in,
    input  logic [6:0]          in_data,
    input  logic                in_empty,
    output logic                in_read,
    output logic [6:0]          out_data,
    output logic                out_write,
    input  logic                out_ready,
    output logic [COL_BITS-1:0] col_out
);

    localparam logic [6:0] CH_BEL   = 7'h07;
    localparam logic [6:0] CH_BS    = 7'h08;
    localparam logic [6:0] CH_LF    = 7'h0A;
    localparam logic [6:0] CH_CR    = 7'h0D;
    localparam logic [6:0] CH_SPACE = 7'h20;
    localparam logic [6:0] CH_TILDE = 7'h7E;
    localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        WAIT,
        TAB,
        HOLD
    } state_t;

    state_t     state;
    logic [6:0] char_q;

`ifdef CHAR_FILTER_TAB_EN
    localparam logic [6:0] CH_TAB  = 7'h09;
    localparam int         TC_BITS = $clog2(TAB_WIDTH + 1);
    localparam logic [COL_BITS-1:0] TAB_MASK = COL_BITS'(TAB_WIDTH - 1);

    logic [TC_BITS-1:0] tab_cnt;
    logic [TC_BITS-1:0] tab_load;
`endif

    logic                is_print;
    logic                is_keep;
    logic [COL_BITS-1:0] col_inc;
    logic [COL_BITS-1:0] col_next;

    // Character class and the column each class produces once it is emitted.
    always_comb begin
        is_print = (char_q >= CH_SPACE) && (char_q <= CH_TILDE);
        is_keep  = (char_q == CH_LF) || (char_q == CH_BEL);
        col_inc  = (col_out == COL_LAST) ? '0 : col_out + 1'b1;
        col_next = col_out;
        if (is_print) begin
            col_next = col_inc;
        end else if (char_q == CH_CR) begin
            col_next = '0;
        end else if (char_q == CH_BS) begin
            col_next = col_out - 1'b1;
        end
`ifdef CHAR_FILTER_TAB_EN
        // Distance to the next tab stop, 1..TAB_WIDTH.
        tab_load = TC_BITS'(TAB_WIDTH) - TC_BITS'(col_out & TAB_MASK);
`endif
    end

    // Main control: pop, classify, emit with handshake, then one idle HOLD cycle.
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state     <= IDLE;
            char_q    <= '0;
            in_read   <= 1'b0;
            out_write <= 1'b0;
            out_data  <= '0;
            col_out   <= '0;
`ifdef CHAR_FILTER_TAB_EN
            tab_cnt   <= '0;
`endif
        end else begin
            in_read   <= 1'b0;
            out_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (!in_empty) begin
                        char_q  <= in_data;
                        in_read <= 1'b1;
                        state   <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_print || is_keep || (char_q == CH_CR)) begin
                        state <= WAIT;
                    end else if (char_q == CH_BS) begin
                        state <= (col_out != '0) ? WAIT : IDLE;
`ifdef CHAR_FILTER_TAB_EN
                    end else if (char_q == CH_TAB) begin
                        tab_cnt <= tab_load;
                        state   <= TAB;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (out_ready) begin
                        out_data  <= char_q;
                        out_write <= 1'b1;
                        col_out   <= col_next;
                        state     <= HOLD;
                    end
                end
`ifdef CHAR_FILTER_TAB_EN
                TAB: begin
                    if (out_ready) begin
                        out_data  <= CH_SPACE;
                        out_write <= 1'b1;
                        col_out   <= col_inc;
                        // A row wrap ends the expansion early.
                        tab_cnt   <= (col_out == COL_LAST) ? '0 : tab_cnt - 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    state <= (tab_cnt != '0) ? TAB : IDLE;
                end
`else
                HOLD: begin
                    state <= IDLE;
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_filter.sv
module tb_char_filter;

    localparam int COLS      = 80;
    localparam int COL_BITS  = 7;
    localparam int TAB_WIDTH = 8;

    logic                clk_in    = 1'b0;
    logic                rstn_in   = 1'b0;
    logic [6:0]          in_data   = '0;
    logic                in_empty  = 1'b1;
    logic                in_read;
    logic [6:0]          out_data;
    logic                out_write;
    logic                out_ready = 1'b0;
    logic [COL_BITS-1:0] col_out;

    char_filter #(.COLS(COLS), .COL_BITS(COL_BITS), .TAB_WIDTH(TAB_WIDTH)) dut (
        .clk_in    (clk_in),
        .rstn_in   (rstn_in),
        .in_data   (in_data),
        .in_empty  (in_empty),
        .in_read   (in_read),
        .out_data  (out_data),
        .out_write (out_write),
        .out_ready (out_ready),
        .col_out   (col_out)
    );

    always #10 clk_in = ~clk_in;

    typedef struct {
        int d;
        int col;
    } exp_t;

    int         checks = 0;
    int         passes = 0;
    logic [6:0] fifo_q[$];
    exp_t       exp_q[$];
    int         mcol = 0;
    int         shown_col = 0;
    int         n_reads = 0;
    int         n_writes = 0;
    int         last_wr = 0;
    int         cyc = 0;
    int         last_read_cyc = 0;
    int         last_write_cyc = 0;
    bit         prev_wr = 1'b0;
    bit         prev_rdy = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push_exp(input int d, input int col);
        exp_t e;
        e.d   = d;
        e.col = col;
        exp_q.push_back(e);
    endtask

    // Reference behaviour: what a popped character must produce on the display.
    task automatic model_char(input logic [6:0] c);
        int n;
        if (c >= 7'h20 && c <= 7'h7E) begin
            mcol = (mcol + 1) % COLS;
            push_exp(c, mcol);
        end else if (c == 7'h0D) begin
            mcol = 0;
            push_exp(c, mcol);
        end else if (c == 7'h0A || c == 7'h07) begin
            push_exp(c, mcol);
        end else if (c == 7'h08) begin
            if (mcol > 0) begin
                mcol = mcol - 1;
                push_exp(c, mcol);
            end
`ifdef CHAR_FILTER_TAB_EN
        end else if (c == 7'h09) begin
            n = TAB_WIDTH - (mcol % TAB_WIDTH);
            for (int i = 0; i < n; i++) begin
                mcol = (mcol + 1) % COLS;
                push_exp(32'h20, mcol);
                if (mcol == 0) break;
            end
`endif
        end
    endtask

    // FIFO emulation and per-cycle comparison against the model.
    initial begin
        logic [6:0] c;
        exp_t       e;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (!rstn_in) begin
                chk("rst_in_read", in_read, 0);
                chk("rst_out_write", out_write, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_col_out", col_out, 0);
                exp_q.delete();
                mcol      = 0;
                shown_col = 0;
                prev_wr   = 1'b0;
                prev_rdy  = 1'b0;
            end else begin
                if (in_read) begin
                    n_reads++;
                    last_read_cyc = cyc;
                    chk("read_while_pending", exp_q.size(), 0);
                    chk("read_fifo_nonempty", fifo_q.size() > 0, 1);
                    if (fifo_q.size() > 0) begin
                        c = fifo_q.pop_front();
                        model_char(c);
                    end
                end
                if (out_write) begin
                    n_writes++;
                    last_write_cyc = cyc;
                    last_wr        = out_data;
                    chk("write_after_ready", prev_rdy, 1);
                    chk("write_back_to_back", prev_wr, 0);
                    chk("write_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.d);
                        chk("col_after_write", col_out, e.col);
                        shown_col = e.col;
                    end
                end else begin
                    chk("col_out_steady", col_out, shown_col);
                end
                prev_wr  = out_write;
                prev_rdy = out_ready;
            end
            in_empty = (fifo_q.size() == 0);
            in_data  = (fifo_q.size() == 0) ? 7'h00 : fifo_q[0];
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk_in);
        #1 rstn_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rstn_in = 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (fifo_q.size() == 0 && exp_q.size() == 0 &&
                cyc - last_read_cyc > 4 && cyc - last_write_cyc > 4) begin
                done = 1'b1;
                break;
            end
        end
        chk(name, done, 1);
    endtask

    task automatic push_n(input int n, input logic [6:0] c);
        for (int i = 0; i < n; i++) fifo_q.push_back(c);
    endtask

    function automatic logic [6:0] rand_char();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 7'h09;
            1: return 7'h08;
            2: return 7'h0D;
            3: return 7'h0A;
            4: return 7'($urandom_range(0, 31));
            5: return 7'h7F;
            default: return 7'($urandom_range(32, 126));
        endcase
    endfunction

    initial begin
        int r0;
        int w0;
        bit seen;

        // Reset state.
        repeat (3) tick();
        chk("reset_col", col_out, 0);
        chk("reset_write", out_write, 0);
        @(posedge clk_in);
        #1 rstn_in = 1'b1;
        out_ready = 1'b1;

        // Single 'A': pop then write two cycles after the pop strobe.
        r0 = n_reads; w0 = n_writes;
        fifo_q.push_back(7'h41);
        drain("drain_A", 50);
        chk("A_reads", n_reads - r0, 1);
        chk("A_writes", n_writes - w0, 1);
        chk("A_data", last_wr, 32'h41);
        chk("A_latency", last_write_cyc - last_read_cyc, 2);
        chk("A_col", col_out, 1);

        // Row wrap: 80 printables then 'B'.
        do_reset();
        push_n(79, 7'h2E);
        drain("drain_79", 600);
        chk("col_79", col_out, 79);
        fifo_q.push_back(7'h2E);
        drain("drain_80", 50);
        chk("col_wrap", col_out, 0);
        fifo_q.push_back(7'h42);
        drain("drain_B", 50);
        chk("col_after_B", col_out, 1);

        // Backspace at column 0 is dropped; after "AB" it steps back.
        do_reset();
        w0 = n_writes;
        fifo_q.push_back(7'h08);
        drain("drain_bs0", 50);
        chk("bs0_writes", n_writes - w0, 0);
        chk("bs0_col", col_out, 0);
        w0 = n_writes;
        fifo_q.push_back(7'h41); fifo_q.push_back(7'h42); fifo_q.push_back(7'h08);
        drain("drain_ab_bs", 80);
        chk("ab_bs_writes", n_writes - w0, 3);
        chk("ab_bs_col", col_out, 1);

        // TAB from column 3 and from column 78.
        do_reset();
        push_n(3, 7'h78);
        drain("drain_col3", 80);
        w0 = n_writes;
        fifo_q.push_back(7'h09);
        drain("drain_tab3", 80);
`ifdef CHAR_FILTER_TAB_EN
        chk("tab3_writes", n_writes - w0, 5);
        chk("tab3_col", col_out, 8);
        chk("tab3_data", last_wr, 32'h20);
`else
        chk("tab3_writes", n_writes - w0, 0);
        chk("tab3_col", col_out, 3);
`endif
        do_reset();
        push_n(78, 7'h79);
        drain("drain_col78", 600);
        w0 = n_writes;
        fifo_q.push_back(7'h09);
        drain("drain_tab78", 80);
`ifdef CHAR_FILTER_TAB_EN
        chk("tab78_writes", n_writes - w0, 2);
        chk("tab78_col", col_out, 0);
`else
        chk("tab78_writes", n_writes - w0, 0);
        chk("tab78_col", col_out, 78);
`endif

        // Dropped control codes around one printable.
        do_reset();
        r0 = n_reads; w0 = n_writes;
        fifo_q.push_back(7'h00); fifo_q.push_back(7'h1B);
        fifo_q.push_back(7'h7F); fifo_q.push_back(7'h43);
        drain("drain_ctrl", 80);
        chk("ctrl_reads", n_reads - r0, 4);
        chk("ctrl_writes", n_writes - w0, 1);
        chk("ctrl_data", last_wr, 32'h43);

        // Display stalled for 100 cycles with 3 characters queued.
        @(posedge clk_in);
        #1 out_ready = 1'b0;
        r0 = n_reads; w0 = n_writes;
        fifo_q.push_back(7'h31); fifo_q.push_back(7'h32); fifo_q.push_back(7'h33);
        repeat (100) tick();
        chk("stall_reads", n_reads - r0, 1);
        chk("stall_writes", n_writes - w0, 0);
        @(posedge clk_in);
        #1 out_ready = 1'b1;
        drain("drain_stall", 80);
        chk("stall_release_writes", n_writes - w0, 3);
        chk("stall_last_data", last_wr, 32'h33);

        // Asynchronous reset while an emission is in progress.
        seen = 1'b0;
`ifdef CHAR_FILTER_TAB_EN
        w0 = n_writes;
        fifo_q.push_back(7'h09);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (n_writes > w0) begin seen = 1'b1; break; end
        end
        chk("tab_started", seen, 1);
`else
        out_ready = 1'b0;
        r0 = n_reads;
        fifo_q.push_back(7'h5A);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (n_reads > r0) begin seen = 1'b1; break; end
        end
        chk("char_popped", seen, 1);
`endif
        #2 rstn_in = 1'b0;
        #1;
        chk("async_rst_write", out_write, 0);
        chk("async_rst_data", out_data, 0);
        chk("async_rst_col", col_out, 0);
        chk("async_rst_read", in_read, 0);
        repeat (2) @(posedge clk_in);
        #1 rstn_in = 1'b1;
        out_ready = 1'b1;
        w0 = n_writes;
        repeat (30) tick();
        chk("post_reset_writes", n_writes - w0, 0);
        chk("post_reset_col", col_out, 0);

        // Randomized traffic with a randomly toggling ready.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_in);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0 && fifo_q.size() < 8) fifo_q.push_back(rand_char());
        end
        @(posedge clk_in);
        #1 out_ready = 1'b1;
        drain("drain_random", 2000);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
